collision_arbiter: RTL and testbench

Parametrised collision arbiter for the VGA game core. It takes per-pixel drawing requests from `NUM_OBJ` sprites (player, shots, invaders, shields, borders) and detects overlap for every enabled unordered object pair. For each pair it emits a single-cycle hit pulse, rate-limited by a per-pair frame cooldown. At each frame boundary it latches a per-frame contact summary and the first pair hit. It sits between the object drawers and the game-state / score logic, and replaces the fixed two-input controller.

---
 rtl/collision_pkg.sv | 15 +
 rtl/collision_pair_tracker.sv | 43 ++++
 rtl/collision_arbiter.sv | 118 +++++++++++
 tb/tb_collision_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - pair mapping helpers and cooldown width shared by the collision arbiter
package collision_pkg;

    localparam int CNT_W = 4;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Row-major index of unordered pair (i,j), i<j, among n objects
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - i * (i + 1) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/collision_pair_tracker.sv
// rtl/collision_pair_tracker.sv - per-pair frame cooldown and single-cycle hit pulse
module collision_pair_tracker
    import collision_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             raw,
    input  logic             startOfFrame,
    input  logic [CNT_W-1:0] hold_frames,
    output logic             hit_now,
    output logic             hit_pulse
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_pulse_q, hit_pulse_d;
    logic             armed;

    always_comb begin
        armed       = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && startOfFrame);
        // Suppressing a hit right after a pulse keeps pulses from ever abutting
        hit_now     = raw && armed && !hit_pulse_q;
        hit_pulse_d = hit_now;
        cnt_d       = cnt_q;
        if (hit_now) begin
            cnt_d = hold_frames;
        end else if (startOfFrame && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q       <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hit_pulse_q <= hit_pulse_d;
        end
    end

    assign hit_pulse = hit_pulse_q;

endmodule

// File: rtl/collision_arbiter.sv
// rtl/collision_arbiter.sv - pairwise sprite overlap detection with per-frame contact summary
module collision_arbiter
    import collision_pkg::*;
#(
    parameter int                   NUM_OBJ     = 4,
    parameter int                   NUM_PAIRS   = num_pairs(NUM_OBJ),
    parameter logic [NUM_PAIRS-1:0] PAIR_EN     = '1,
    parameter int                   HOLD_FRAMES = 1,
    localparam int                  FP_W        = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic [NUM_OBJ-1:0]   draw_req,
    output logic                 collision,
    output logic [NUM_PAIRS-1:0] hit_pulse,
    output logic                 any_hit_pulse,
    output logic [NUM_PAIRS-1:0] frame_summary,
    output logic                 summary_valid,
    output logic [FP_W-1:0]      first_pair,
    output logic                 first_valid
);

    logic [NUM_PAIRS-1:0] raw;
    logic [NUM_PAIRS-1:0] hit_now;
    logic [FP_W-1:0]      first_idx;
    logic                 hit_any;

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_i
        for (genvar gj = gi + 1; gj < NUM_OBJ; gj++) begin : g_j
            localparam int P = pair_idx(gi, gj, NUM_OBJ);
            assign raw[P] = draw_req[gi] & draw_req[gj] & PAIR_EN[P];
        end
    end

    for (genvar gp = 0; gp < NUM_PAIRS; gp++) begin : g_trk
        collision_pair_tracker u_trk (
            .clk          (clk),
            .resetN       (resetN),
            .raw          (raw[gp]),
            .startOfFrame (startOfFrame),
            .hold_frames  (CNT_W'(HOLD_FRAMES)),
            .hit_now      (hit_now[gp]),
            .hit_pulse    (hit_pulse[gp])
        );
    end

    assign collision = |raw;
    assign hit_any   = |hit_now;

    always_comb begin
        first_idx = '0;
        for (int p = NUM_PAIRS - 1; p >= 0; p--) begin
            if (hit_now[p]) first_idx = FP_W'(p);
        end
    end

    logic [NUM_PAIRS-1:0] acc_q, acc_d;
    logic [FP_W-1:0]      first_acc_q, first_acc_d;
    logic                 first_acc_v_q, first_acc_v_d;
    logic [NUM_PAIRS-1:0] frame_summary_q, frame_summary_d;
    logic [FP_W-1:0]      first_pair_q, first_pair_d;
    logic                 first_valid_q, first_valid_d;
    logic                 summary_valid_q, summary_valid_d;
    logic                 any_hit_q, any_hit_d;

    always_comb begin
        acc_d           = acc_q | raw;
        first_acc_d     = first_acc_q;
        first_acc_v_d   = first_acc_v_q;
        frame_summary_d = frame_summary_q;
        first_pair_d    = first_pair_q;
        first_valid_d   = first_valid_q;
        summary_valid_d = startOfFrame;
        any_hit_d       = hit_any;
        if (startOfFrame) begin
            // The boundary cycle's own activity opens the new frame
            frame_summary_d = acc_q;
            first_pair_d    = first_acc_q;
            first_valid_d   = first_acc_v_q;
            acc_d           = raw;
            first_acc_d     = first_idx;
            first_acc_v_d   = hit_any;
        end else if (!first_acc_v_q && hit_any) begin
            first_acc_d   = first_idx;
            first_acc_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q           <= '0;
            first_acc_q     <= '0;
            first_acc_v_q   <= 1'b0;
            frame_summary_q <= '0;
            first_pair_q    <= '0;
            first_valid_q   <= 1'b0;
            summary_valid_q <= 1'b0;
            any_hit_q       <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            first_acc_q     <= first_acc_d;
            first_acc_v_q   <= first_acc_v_d;
            frame_summary_q <= frame_summary_d;
            first_pair_q    <= first_pair_d;
            first_valid_q   <= first_valid_d;
            summary_valid_q <= summary_valid_d;
            any_hit_q       <= any_hit_d;
        end
    end

    assign any_hit_pulse = any_hit_q;
    assign frame_summary = frame_summary_q;
    assign summary_valid = summary_valid_q;
    assign first_pair    = first_pair_q;
    assign first_valid   = first_valid_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// tb/tb_collision_arbiter.sv - randomized and directed checks of collision_arbiter against a frame-level model
module tb_collision_arbiter;

    localparam int NP = 6;

    logic          clk = 1'b0;
    logic          resetN;
    logic          sof;
    logic [3:0]    draw_req;

    logic          col_o [2];
    logic [NP-1:0] hit_o [2];
    logic          any_o [2];
    logic [NP-1:0] sum_o [2];
    logic          sv_o  [2];
    logic [2:0]    fp_o  [2];
    logic          fv_o  [2];

    always #5 clk = ~clk;

    collision_arbiter #(.NUM_OBJ(4), .PAIR_EN(6'b111111), .HOLD_FRAMES(1)) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(draw_req),
        .collision(col_o[0]), .hit_pulse(hit_o[0]), .any_hit_pulse(any_o[0]),
        .frame_summary(sum_o[0]), .summary_valid(sv_o[0]),
        .first_pair(fp_o[0]), .first_valid(fv_o[0])
    );

    collision_arbiter #(.NUM_OBJ(4), .PAIR_EN(6'b111110), .HOLD_FRAMES(3)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .draw_req(draw_req),
        .collision(col_o[1]), .hit_pulse(hit_o[1]), .any_hit_pulse(any_o[1]),
        .frame_summary(sum_o[1]), .summary_valid(sv_o[1]),
        .first_pair(fp_o[1]), .first_valid(fv_o[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a pair is armed when at least hold frames have passed since its last hit
    int            hold_m [2] = '{1, 3};
    logic [NP-1:0] en_m   [2] = '{6'b111111, 6'b111110};
    int            frame_n;
    int            last_f  [2][NP];
    logic [NP-1:0] prev_h  [2];
    logic [NP-1:0] acc_m   [2];
    logic [2:0]    fa_m    [2];
    logic          fv_m    [2];
    logic          exp_col [2];
    logic [NP-1:0] exp_hit [2];
    logic          exp_any [2];
    logic [NP-1:0] exp_sum [2];
    logic          exp_sv  [2];
    logic [2:0]    exp_fp  [2];
    logic          exp_fv  [2];

    function automatic logic [2:0] lowest(input logic [NP-1:0] v);
        logic [2:0] r;
        logic       found;
        r = 3'd0;
        found = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (v[p] && !found) begin
                r = 3'(p);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        frame_n = 0;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NP; p++) last_f[k][p] = -100;
            prev_h[k]  = '0;
            acc_m[k]   = '0;
            fa_m[k]    = '0;
            fv_m[k]    = 1'b0;
            exp_col[k] = 1'b0;
            exp_hit[k] = '0;
            exp_any[k] = 1'b0;
            exp_sum[k] = '0;
            exp_sv[k]  = 1'b0;
            exp_fp[k]  = '0;
            exp_fv[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] dr, input logic s);
        if (s) frame_n++;
        for (int k = 0; k < 2; k++) begin
            logic [NP-1:0] raw;
            logic [NP-1:0] hits;
            int            p;
            raw  = '0;
            hits = '0;
            p    = 0;
            if (s) begin
                exp_sum[k] = acc_m[k];
                exp_fp[k]  = fa_m[k];
                exp_fv[k]  = fv_m[k];
            end
            exp_sv[k] = s;
            for (int i = 0; i < 4; i++) begin
                for (int j = i + 1; j < 4; j++) begin
                    raw[p] = dr[i] & dr[j] & en_m[k][p];
                    if (raw[p] && (frame_n - last_f[k][p] >= hold_m[k]) && !prev_h[k][p]) begin
                        hits[p]      = 1'b1;
                        last_f[k][p] = frame_n;
                    end
                    p++;
                end
            end
            prev_h[k]  = hits;
            exp_col[k] = |raw;
            exp_hit[k] = hits;
            exp_any[k] = |hits;
            if (s) begin
                acc_m[k] = raw;
                fv_m[k]  = |hits;
                fa_m[k]  = lowest(hits);
            end else begin
                acc_m[k] = acc_m[k] | raw;
                if (!fv_m[k] && (|hits)) begin
                    fv_m[k] = 1'b1;
                    fa_m[k] = lowest(hits);
                end
            end
        end
    endtask

    task automatic cycle(input logic [3:0] dr, input logic s);
        @(negedge clk);
        draw_req = dr;
        sof      = s;
        #1;
        model_step(dr, s);
        for (int k = 0; k < 2; k++) check($sformatf("collision%0d", k), col_o[k], exp_col[k]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("hit_pulse%0d", k),     hit_o[k], exp_hit[k]);
            check($sformatf("any_hit%0d", k),       any_o[k], exp_any[k]);
            check($sformatf("frame_summary%0d", k), sum_o[k], exp_sum[k]);
            check($sformatf("summary_valid%0d", k), sv_o[k],  exp_sv[k]);
            check($sformatf("first_pair%0d", k),    fp_o[k],  exp_fp[k]);
            check($sformatf("first_valid%0d", k),   fv_o[k],  exp_fv[k]);
        end
    endtask

    // Reset lands mid-cycle so the outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        resetN   = 1'b0;
        draw_req = '0;
        sof      = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_collision%0d", k), col_o[k], 0);
            check($sformatf("rst_hit%0d", k),       hit_o[k], 0);
            check($sformatf("rst_any%0d", k),       any_o[k], 0);
            check($sformatf("rst_summary%0d", k),   sum_o[k], 0);
            check($sformatf("rst_sv%0d", k),        sv_o[k],  0);
            check($sformatf("rst_fp%0d", k),        fp_o[k],  0);
            check($sformatf("rst_fv%0d", k),        fv_o[k],  0);
        end
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        resetN   = 1'b0;
        sof      = 1'b0;
        draw_req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // single overlap mid-frame
        cycle(4'b0000, 1'b0);
        cycle(4'b0011, 1'b0);
        check("single_col_a", col_o[0], 1);
        check("single_hit_a", hit_o[0], 6'b000001);
        check("masked_col_b", col_o[1], 0);
        check("masked_hit_b", hit_o[1], 0);
        cycle(4'b0011, 1'b0);
        check("single_hit2_a", hit_o[0], 0);
        cycle(4'b0011, 1'b0);
        check("single_hit3_a", hit_o[0], 0);
        cycle(4'b0000, 1'b1);
        check("single_sum_a", sum_o[0], 6'b000001);
        check("single_fp_a", fp_o[0], 0);
        check("single_fv_a", fv_o[0], 1);
        check("masked_sum_b", sum_o[1], 0);

        // simultaneous hits, then ordered hits across a frame
        cycle(4'b1111, 1'b0);
        check("simul_hit_a", hit_o[0], 6'b111111);
        check("simul_hit_b", hit_o[1], 6'b111110);
        cycle(4'b0000, 1'b1);
        check("simul_fp_a", fp_o[0], 0);
        cycle(4'b0110, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b1001, 1'b0);
        cycle(4'b0000, 1'b1);
        check("order_fp_a", fp_o[0], 3);
        check("order_fv_a", fv_o[0], 1);

        // overlap only in the boundary cycle
        cycle(4'b0011, 1'b1);
        check("bound_hit_a", hit_o[0][0], 1);
        check("bound_sum0_a", sum_o[0][0], 0);
        cycle(4'b0000, 1'b1);
        check("bound_sum1_a", sum_o[0][0], 1);

        // cooldown of pair (1,3) with a three-frame hold
        do_reset();
        for (int f = 0; f < 8; f++) begin
            cycle(4'b0000, 1'b1);
            if (f > 0) check($sformatf("cool_sum_f%0d", f), sum_o[1][4], 1);
            cycle(4'b1010, 1'b0);
            check($sformatf("cool_hit_f%0d", f), hit_o[1][4], (f % 3) == 0);
            cycle(4'b0000, 1'b0);
        end
        do_reset();
        cycle(4'b1010, 1'b0);
        check("post_rst_hit_b", hit_o[1][4], 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] dr;
            logic       s;
            if ($urandom_range(0, 1) == 0) dr = 4'($urandom);
            else                           dr = 4'($urandom & $urandom);
            s = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle(dr, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
